// File: rtl/wvb_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wvb_rd_arb_pkg
// Brief    : Shared state encoding and default timing constants for the
//            waveform-buffer readout arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wvb_rd_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_BUSY   = 2'd2,
        S_SETTLE = 2'd3
    } arb_state_t;

    // Idle cycles after a release, long enough for hdr_empty to reflect the read
    localparam int C_DEF_SETTLE        = 3;
    localparam int C_DEF_TIMEOUT_WIDTH = 16;

endpackage : wvb_rd_arb_pkg
`default_nettype wire

// File: rtl/wvb_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin picker. Rotates the request vector so
//            that the channel after 'last' sits at bit 0, priority-encodes the
//            lowest set bit, then rotates the result back to a channel index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int P_N_CHAN    = 24,
    parameter int P_IDX_WIDTH = 5
) (
    input  logic [P_N_CHAN-1:0]    req,
    input  logic [P_IDX_WIDTH-1:0] last,
    output logic                   valid,
    output logic [P_IDX_WIDTH-1:0] idx
);

    localparam logic [P_IDX_WIDTH:0]   C_N    = (P_IDX_WIDTH+1)'(P_N_CHAN);
    localparam logic [P_IDX_WIDTH-1:0] C_LAST = P_IDX_WIDTH'(P_N_CHAN - 1);

    logic [P_IDX_WIDTH-1:0] w_base;
    logic [P_N_CHAN-1:0]    w_rot;
    logic [P_IDX_WIDTH-1:0] w_pos;
    logic [P_IDX_WIDTH:0]   w_sum;

    // Search starts one past the last grant; wraps at the channel count
    always_comb begin
        w_base = (last >= C_LAST) ? '0 : last + P_IDX_WIDTH'(1);
    end

    // Rotate: bit j of w_rot is channel (base + j) mod P_N_CHAN
    generate
        for (genvar j = 0; j < P_N_CHAN; j++) begin : g_rot
            logic [P_IDX_WIDTH:0] w_src;
            logic [P_IDX_WIDTH:0] w_wrap;
            assign w_src    = {1'b0, w_base} + (P_IDX_WIDTH+1)'(j);
            assign w_wrap   = (w_src >= C_N) ? (w_src - C_N) : w_src;
            assign w_rot[j] = req[w_wrap[P_IDX_WIDTH-1:0]];
        end
    endgenerate

    // Priority encode the lowest set bit of the rotated vector
    always_comb begin
        valid = 1'b0;
        w_pos = '0;
        for (int j = P_N_CHAN - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                valid = 1'b1;
                w_pos = P_IDX_WIDTH'(j);
            end
        end
    end

    // Un-rotate the encoded position back to an absolute channel index
    always_comb begin
        w_sum = {1'b0, w_base} + {1'b0, w_pos};
        if (w_sum >= C_N) begin
            w_sum = w_sum - C_N;
        end
        idx = w_sum[P_IDX_WIDTH-1:0];
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/wvb_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wvb_rd_arbiter
// Brief    : Round-robin arbiter sharing one waveform reader among the channel
//            waveform buffers. Grants one non-empty channel at a time, routes
//            the reader strobes to it, and releases on done or watchdog expiry.
// Revision : 1.0 - initial release
// ============================================================================
module wvb_rd_arbiter
    import wvb_rd_arb_pkg::*;
#(
    parameter int P_N_CHAN        = 24,
    parameter int P_IDX_WIDTH     = 5,
    parameter int P_TIMEOUT_WIDTH = C_DEF_TIMEOUT_WIDTH,
    parameter int P_SETTLE        = C_DEF_SETTLE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [P_TIMEOUT_WIDTH-1:0] timeout_conf,
    input  logic [P_N_CHAN-1:0]        hdr_empty,
    input  logic                       rdr_wvb_rdreq,
    input  logic                       rdr_hdr_rdreq,
    input  logic                       rdr_rddone,
    input  logic                       rdr_done,
    output logic [P_N_CHAN-1:0]        wvb_rdreq,
    output logic [P_N_CHAN-1:0]        hdr_rdreq,
    output logic [P_N_CHAN-1:0]        wvb_rddone,
    output logic [P_IDX_WIDTH-1:0]     chan_sel,
    output logic                       rdr_go,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int                    C_SETTLE_W    = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam logic [C_SETTLE_W-1:0] C_SETTLE_LAST = C_SETTLE_W'(P_SETTLE - 1);

    arb_state_t                 state_q, state_d;
    logic [P_IDX_WIDTH-1:0]     chan_sel_q, chan_sel_d;
    logic [P_IDX_WIDTH-1:0]     last_q, last_d;
    logic [P_TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic [C_SETTLE_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic                       rdr_go_q, rdr_go_d;
    logic                       busy_q, busy_d;
    logic                       timeout_err_q, timeout_err_d;

    logic                       w_pick_valid;
    logic [P_IDX_WIDTH-1:0]     w_pick_idx;
    logic                       w_wd_expire;

    rr_priority_pick #(
        .P_N_CHAN    (P_N_CHAN),
        .P_IDX_WIDTH (P_IDX_WIDTH)
    ) u_pick (
        .req   (~hdr_empty),
        .last  (last_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Watchdog fires on the last allowed busy cycle; a zero limit disables it
    assign w_wd_expire = (timeout_conf != '0) &&
                         (wd_cnt_q == timeout_conf - P_TIMEOUT_WIDTH'(1));

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        chan_sel_d    = chan_sel_q;
        last_d        = last_q;
        wd_cnt_d      = wd_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        rdr_go_d      = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && w_pick_valid) begin
                    chan_sel_d = w_pick_idx;
                    last_d     = w_pick_idx;
                    rdr_go_d   = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                wd_cnt_d = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                wd_cnt_d = wd_cnt_q + P_TIMEOUT_WIDTH'(1);
                // Reader completion takes precedence over a coincident expiry
                if (rdr_done) begin
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end else if (w_wd_expire) begin
                    timeout_err_d = 1'b1;
                    settle_cnt_d  = '0;
                    state_d       = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == C_SETTLE_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + C_SETTLE_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any read in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            chan_sel_q    <= '0;
            last_q        <= P_IDX_WIDTH'(P_N_CHAN - 1);
            wd_cnt_q      <= '0;
            settle_cnt_q  <= '0;
            rdr_go_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            chan_sel_q    <= chan_sel_d;
            last_q        <= last_d;
            wd_cnt_q      <= wd_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            rdr_go_q      <= rdr_go_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Strobe demux: only the granted channel sees reader strobes, only in S_BUSY
    always_comb begin
        wvb_rdreq  = '0;
        hdr_rdreq  = '0;
        wvb_rddone = '0;
        if (state_q == S_BUSY) begin
            for (int i = 0; i < P_N_CHAN; i++) begin
                if (chan_sel_q == P_IDX_WIDTH'(i)) begin
                    wvb_rdreq[i]  = rdr_wvb_rdreq;
                    hdr_rdreq[i]  = rdr_hdr_rdreq;
                    wvb_rddone[i] = rdr_rddone;
                end
            end
        end
    end

    assign chan_sel    = chan_sel_q;
    assign rdr_go      = rdr_go_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule : wvb_rd_arbiter
`default_nettype wire

// File: doc/wvb_rd_arbiter.md
# wvb_rd_arbiter

Round-robin readout arbiter that shares one `wvb_reader` among the 24 channel `waveform_buffer` instances. It watches each buffer's header-FIFO `hdr_empty` flag and grants the reader to one non-empty channel at a time. While a channel is granted, it routes the reader's `wvb_rdreq`/`hdr_rdreq`/`wvb_rddone` strobes to that channel only. It releases the grant on reader completion or on a watchdog timeout.

## Interface
Parameters:
- `P_N_CHAN`, 24, number of waveform buffers
- `P_IDX_WIDTH`, 5, width of channel index (≥ clog2(`P_N_CHAN`))
- `P_TIMEOUT_WIDTH`, 16, width of watchdog counter
- `P_SETTLE`, 3, idle cycles after release before next arbitration (covers `hdr_empty` update latency)

Ports:
- `clk` in 1 — system clock
- `rst` in 1 — reset; one clock; reset is asynchronous and active-high
- `en` in 1 — arbitration enable
- `timeout_conf` in `P_TIMEOUT_WIDTH` — watchdog limit in cycles; 0 disables watchdog
- `hdr_empty` in `P_N_CHAN` — per-channel header-FIFO empty flags
- `rdr_wvb_rdreq` in 1 — reader waveform read strobe
- `rdr_hdr_rdreq` in 1 — reader header read strobe
- `rdr_rddone` in 1 — reader done strobe to buffer
- `rdr_done` in 1 — reader finished current waveform (pulse)
- `wvb_rdreq` out `P_N_CHAN` — demuxed to granted channel
- `hdr_rdreq` out `P_N_CHAN` — demuxed
- `wvb_rddone` out `P_N_CHAN` — demuxed
- `chan_sel` out `P_IDX_WIDTH` — granted channel index; drives the reader data mux
- `rdr_go` out 1 — one-cycle start pulse to reader
- `busy` out 1 — grant held
- `timeout_err` out 1 — one-cycle pulse on watchdog expiry

## Operation
- States: `S_IDLE`, `S_START`, `S_BUSY`, `S_SETTLE`.
- `S_IDLE`: if `en` and any `~hdr_empty`, pick the first non-empty channel searching `last+1, last+2, … last+P_N_CHAN` (mod `P_N_CHAN`).
  - Register `chan_sel`, update `last`, go `S_START`.
  - Otherwise stay in `S_IDLE`.
- `S_START`: `rdr_go`=1 for exactly this cycle; clear watchdog; go `S_BUSY`.
- `S_BUSY`:
  - Outputs `wvb_rdreq[chan_sel]`, `hdr_rdreq[chan_sel]`, `wvb_rddone[chan_sel]` equal the reader inputs. All other bits, and all bits in other states, are 0.
  - Watchdog increments each cycle.
  - `rdr_done` → `S_SETTLE`.
  - Else if `timeout_conf`≠0 and count == `timeout_conf`-1: pulse `timeout_err`, → `S_SETTLE`. No `wvb_rddone` is generated by the arbiter.
  - `rdr_done` and expiry in the same cycle: `rdr_done` wins, no error.
- `S_SETTLE`: hold `P_SETTLE` cycles (all demux outputs 0), then `S_IDLE`.
- `busy`=1 in `S_START`, `S_BUSY`, `S_SETTLE`.
- `en` deasserted while busy: current read completes normally; no new grant afterwards.
- Reader strobes arriving outside `S_BUSY` are dropped.
- `chan_sel` holds its value after release until the next grant.
- Reset: state `S_IDLE`, `last`=`P_N_CHAN`-1 (first search starts at channel 0), `chan_sel`=0, all outputs 0, watchdog 0. Reset mid-read aborts immediately with no `rddone`.
- Index arithmetic wraps at `P_N_CHAN`, not 2^`P_IDX_WIDTH`.

## Timing
- `hdr_empty[k]` low sampled at edge t in `S_IDLE` → `chan_sel`=k and `rdr_go`=1 in cycle t+1; `S_BUSY` from t+2.
- Demux is combinational from reader inputs and registered `chan_sel`: zero added latency.
- `rdr_done` sampled at edge t → `busy` stays 1 for `P_SETTLE` more cycles, then drops. Earliest next `rdr_go` is `P_SETTLE`+2 cycles after the `rdr_done` edge.
- `timeout_err` is asserted in the cycle following the expiry edge.

## Structure
- Package `wvb_rd_arb_pkg`: state encoding constants and default `P_SETTLE`/`P_TIMEOUT_WIDTH`.
- Sub-module `rr_priority_pick`: combinational; inputs request vector and last index; outputs `valid` and next index. Implemented as a rotate, a priority encode, then an un-rotate.
- Top: FSM, watchdog counter, settle counter, demux.

## Test plan
- Reset, then `hdr_empty`=all ones except ch 0 → `rdr_go` at the next cycle with `chan_sel`=0. Reader `wvb_rdreq` pulses appear only on `wvb_rdreq[0]`.
- Ch 0, 1, 23 all non-empty and held → grants in order 0, 1, 23, 0, 1, 23. Each `rdr_go` is separated by `rdr_done`+`P_SETTLE`+2 cycles.
- Ch 5 granted; assert `rdr_done` on the same cycle as watchdog expiry (`timeout_conf`=10) → no `timeout_err`; normal release.
- Ch 5 granted, `timeout_conf`=10, no `rdr_done` → `timeout_err` pulse 10 cycles after `S_BUSY` entry; `wvb_rddone` stays all zero; re-arbitration follows.
- `en` dropped mid-read of ch 3 → read finishes and `busy` falls. No `rdr_go` while `en`=0, even with non-empty channels.
- `rst` pulsed mid-`S_BUSY` → all outputs 0 asynchronously. After release, the first grant goes to the lowest-index non-empty channel.
